// File: rtl/audio_adc_receiver.sv
// Codec ADC capture: DSP-mode serial frames (LRC pulse, left, right)
// to parallel stereo samples behind a valid/ready holding register.
//
// Ports:
//   clkin, reset_n        system clock, synchronous active-low reset
//   AUD_BCLK/ADCLRCK/DAT  codec serial inputs, oversampled on clkin
//   sample_left/right     held stereo frame, stable while valid
//   sample_valid/ready    one-deep handshake to the consumer
//   overrun, frame_err    sticky error flags, cleared by clear_err
module audio_adc_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clkin,
  input  logic                  reset_n,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  clear_err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrc_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_q;

  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] left_sr, left_n;
  logic [DATA_WIDTH-1:0] right_sr, right_n;

  logic bclk_s, lrc_s, dat_s;
  logic bclk_rise;
  logic frame_done;
  logic lrc_abort;
  logic load;
  logic drop;

  assign bclk_s = bclk_sync[SYNC_STAGES-1];
  assign lrc_s  = lrc_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];

  assign bclk_rise = bclk_s & ~bclk_q;

  // A completing frame may replace the held one in the same cycle
  // the consumer takes it; otherwise it is lost.
  assign load = frame_done & (~sample_valid | sample_ready);
  assign drop = frame_done & sample_valid & ~sample_ready;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    left_n     = left_sr;
    right_n    = right_sr;
    frame_done = 1'b0;
    lrc_abort  = 1'b0;
    if (bclk_rise) begin
      unique case (state)
        IDLE: begin
          if (lrc_s) begin
            state_n = LEFT;
            cnt_n   = '0;
          end
        end
        LEFT: begin
          if (lrc_s) begin
            lrc_abort = 1'b1;
            cnt_n     = '0;
          end else begin
            left_n = {left_sr[DATA_WIDTH-2:0], dat_s};
            if (cnt == LAST) begin
              state_n = RIGHT;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
        RIGHT: begin
          if (lrc_s) begin
            lrc_abort = 1'b1;
            state_n   = LEFT;
            cnt_n     = '0;
          end else begin
            right_n = {right_sr[DATA_WIDTH-2:0], dat_s};
            if (cnt == LAST) begin
              frame_done = 1'b1;
              state_n    = IDLE;
              cnt_n      = '0;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_q    <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      left_sr   <= '0;
      right_sr  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_q    <= bclk_s;
      state     <= state_n;
      cnt       <= cnt_n;
      left_sr   <= left_n;
      right_sr  <= right_n;
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (load) begin
        sample_left  <= left_sr;
        sample_right <= right_n;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      // A new event wins over a simultaneous clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
      if (lrc_abort) begin
        frame_err <= 1'b1;
      end else if (clear_err) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Directed bench for audio_adc_receiver: serial frames in,
// accepted frames collected by a handshake monitor and compared.
module tb_audio_adc_receiver;

  logic        clkin = 1'b0;
  logic        reset_n = 1'b0;
  logic        AUD_BCLK = 1'b0;
  logic        AUD_ADCLRCK = 1'b0;
  logic        AUD_ADCDAT = 1'b0;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overrun;
  logic        frame_err;
  logic        clear_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  logic [31:0] acc[$];

  always #5 clkin = ~clkin;

  audio_adc_receiver #(
    .DATA_WIDTH(16),
    .SYNC_STAGES(2)
  ) dut (
    .clkin(clkin),
    .reset_n(reset_n),
    .AUD_BCLK(AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun(overrun),
    .frame_err(frame_err),
    .clear_err(clear_err)
  );

  // Sample mid-cycle: inputs settle at negedge, outputs at posedge.
  always @(negedge clkin) begin
    #1;
    if (sample_valid) valid_cycles++;
    if (sample_valid && sample_ready)
      acc.push_back({sample_left, sample_right});
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] first_acc();
    if (acc.size() > 0) return acc[0];
    return 32'hDEAD_BEEF;
  endfunction

  // One BCLK period = 8 clkin cycles, data changes while BCLK low.
  task automatic send_bit(input logic lrc, input logic dat);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lrc;
    AUD_ADCDAT  = dat;
    repeat (4) @(negedge clkin);
    AUD_BCLK = 1'b1;
    repeat (4) @(negedge clkin);
  endtask

  // LRC pulse followed by the first nbits of {l, r}, MSB first.
  task automatic send_frame(input logic [15:0] l,
                            input logic [15:0] r,
                            input int nbits);
    logic [31:0] w;
    w = {l, r};
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < nbits; i++)
      send_bit(1'b0, w[31-i]);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++)
      send_bit(1'b0, i[0]);
  endtask

  initial begin
    repeat (3) @(negedge clkin);
    reset_n = 1'b1;
    @(negedge clkin);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_left", 32'(sample_left), 32'd0);
    chk("rst_right", 32'(sample_right), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);

    // Basic frame, consumer always ready.
    sample_ready = 1'b1;
    acc.delete();
    valid_cycles = 0;
    send_frame(16'hA5C3, 16'h0F01, 32);
    idle_bits(2);
    chk("t1_cnt", 32'(acc.size()), 32'd1);
    chk("t1_data", first_acc(), 32'hA5C3_0F01);
    chk("t1_vcyc", 32'(valid_cycles), 32'd1);
    chk("t1_ovr", 32'(overrun), 32'd0);

    // Consumer stalled for three frames: first held, rest dropped.
    sample_ready = 1'b0;
    acc.delete();
    send_frame(16'h8000, 16'h7FFF, 32);
    idle_bits(1);
    chk("t2_ovr0", 32'(overrun), 32'd0);
    send_frame(16'h1111, 16'h2222, 32);
    idle_bits(1);
    send_frame(16'h3333, 16'h4444, 32);
    idle_bits(1);
    chk("t2_valid", 32'(sample_valid), 32'd1);
    chk("t2_left", 32'(sample_left), 32'h8000);
    chk("t2_right", 32'(sample_right), 32'h7FFF);
    chk("t2_ovr", 32'(overrun), 32'd1);
    sample_ready = 1'b1;
    repeat (3) @(negedge clkin);
    chk("t2_cnt", 32'(acc.size()), 32'd1);
    chk("t2_data", first_acc(), 32'h8000_7FFF);
    chk("t2_vdone", 32'(sample_valid), 32'd0);

    // LRC after 9 left bits aborts; following frame intact.
    acc.delete();
    send_frame(16'hFFFF, 16'hFFFF, 9);
    send_frame(16'h1234, 16'h5678, 32);
    idle_bits(2);
    chk("t3_ferr", 32'(frame_err), 32'd1);
    chk("t3_cnt", 32'(acc.size()), 32'd1);
    chk("t3_data", first_acc(), 32'h1234_5678);

    // Clearing both flags leaves the data path working.
    clear_err = 1'b1;
    @(negedge clkin);
    clear_err = 1'b0;
    chk("t4_ovr", 32'(overrun), 32'd0);
    chk("t4_ferr", 32'(frame_err), 32'd0);
    acc.delete();
    send_frame(16'h0BAD, 16'hF00D, 32);
    idle_bits(1);
    chk("t4_data", first_acc(), 32'h0BAD_F00D);
    chk("t4_cnt", 32'(acc.size()), 32'd1);

    // Reset at right bit 5 discards the partial frame.
    acc.delete();
    send_frame(16'hAAAA, 16'h5555, 21);
    reset_n = 1'b0;
    repeat (2) @(negedge clkin);
    reset_n = 1'b1;
    chk("t5_valid", 32'(sample_valid), 32'd0);
    chk("t5_left", 32'(sample_left), 32'd0);
    chk("t5_right", 32'(sample_right), 32'd0);
    idle_bits(11);
    chk("t5_none", 32'(acc.size()), 32'd0);
    send_frame(16'hFFFF, 16'h0001, 32);
    idle_bits(1);
    chk("t5_cnt", 32'(acc.size()), 32'd1);
    chk("t5_data", first_acc(), 32'hFFFF_0001);

    // Ready rises in the completing cycle: swap without overrun.
    sample_ready = 1'b0;
    acc.delete();
    send_frame(16'h0102, 16'h0304, 32);
    idle_bits(1);
    send_frame(16'h0506, 16'h0708, 31);
    AUD_BCLK   = 1'b0;
    AUD_ADCDAT = 1'b0;
    repeat (4) @(negedge clkin);
    AUD_BCLK = 1'b1;
    repeat (2) @(negedge clkin);
    sample_ready = 1'b1;
    @(negedge clkin);
    sample_ready = 1'b0;
    chk("t6_valid", 32'(sample_valid), 32'd1);
    chk("t6_left", 32'(sample_left), 32'h0506);
    chk("t6_right", 32'(sample_right), 32'h0708);
    chk("t6_ovr", 32'(overrun), 32'd0);
    #2;
    chk("t6_cnt", 32'(acc.size()), 32'd1);
    chk("t6_first", first_acc(), 32'h0102_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
